// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: word widths, reset/bubble constants
// and the next-PC selection encoding used by the fetch stage.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int JIDX_W = 26;

  localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEQ,
    HOLD,
    BRANCH,
    JUMP,
    RESET
  } next_pc_sel_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures a fetched word and its PC+4, holds on
// stall and turns into a bubble on flush or reset.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [WORD_W-1:0] instr_d,
  input  logic [WORD_W-1:0] pc_plus4_d,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              valid
);

  // Flush and reset both leave a bubble; neither load nor flush means hold.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      instr    <= NOP_WORD;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= instr_d;
      pc_plus4 <= pc_plus4_d;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC priority mux, IF/ID register
// and a counter of valid instructions delivered to decode.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [WORD_W-1:0] NOP_WORD = mips_pkg::NOP_WORD,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WORD_W-1:0] pc_out,
  input  logic [WORD_W-1:0] instr_in,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  output logic [WORD_W-1:0] if_id_instr,
  output logic [WORD_W-1:0] if_id_pc_plus4,
  output logic              if_id_valid,
  output logic [CNT_W-1:0]  fetch_count
);

  next_pc_sel_t      sel;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] next_pc;
  logic              load;
  logic              flush;

  assign pc_plus4 = pc_out + 32'd4;

  // Redirects outrank stall because the stalling instruction is being squashed;
  // a branch outranks a jump since the branch belongs to the older instruction.
  always_comb begin
    sel = SEQ;
    if (!reset)            sel = RESET;
    else if (branch_taken) sel = BRANCH;
    else if (jump)         sel = JUMP;
    else if (stall)        sel = HOLD;
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      RESET:   next_pc = RESET_PC;
      BRANCH:  next_pc = branch_target;
      JUMP:    next_pc = {if_id_pc_plus4[31:28], jump_index, 2'b00};
      HOLD:    next_pc = pc_out;
      default: next_pc = pc_plus4;
    endcase
  end

  assign load  = (sel == SEQ);
  assign flush = (sel == BRANCH) || (sel == JUMP);

  // Word alignment is enforced here so byte-offset bits of a branch target never reach memory.
  always_ff @(posedge clk) begin
    pc_out <= next_pc & ~32'h3;
  end

  always_ff @(posedge clk) begin
    if (!reset)    fetch_count <= '0;
    else if (load) fetch_count <= fetch_count + CNT_W'(1);
  end

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .flush     (flush),
    .instr_d   (instr_in),
    .pc_plus4_d(pc_plus4),
    .instr     (if_id_instr),
    .pc_plus4  (if_id_pc_plus4),
    .valid     (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed table of pipeline scenarios, then random
// stall/redirect/reset traffic checked against a rule-level reference model.
module tb_fetch_stage;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      pc_out;
  logic [31:0]      instr_in;
  logic             stall;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [25:0]      jump_index;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc_plus4;
  logic             if_id_valid;
  logic [CNT_W-1:0] fetch_count;

  logic [31:0] mem [32];

  int nApplied = 0;
  int nFail    = 0;

  // Reference model state
  logic [31:0]      mPc;
  logic [31:0]      mInstr;
  logic [31:0]      mPc4;
  logic             mValid;
  logic [CNT_W-1:0] mCnt;

  typedef struct {
    logic             rst;
    logic             st;
    logic             br;
    logic [31:0]      bt;
    logic             jp;
    logic [25:0]      ji;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [31:0]      pc4;
    logic             valid;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  assign instr_in = mem[pc_out[6:2]];

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_WORD(32'h0000_0000),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_out        (pc_out),
    .instr_in      (instr_in),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid),
    .fetch_count   (fetch_count)
  );

  task automatic applyStimulus(input logic r, input logic st, input logic br,
                               input logic [31:0] bt, input logic jp, input logic [25:0] ji);
    reset         = r;
    stall         = st;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_index    = ji;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Rules of the fetch stage stated directly: what the PC and IF/ID become after one edge.
  task automatic modelStep(input logic r, input logic st, input logic br,
                           input logic [31:0] bt, input logic jp, input logic [25:0] ji);
    if (!r) begin
      mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0; mCnt = '0;
    end else if (br || jp) begin
      if (br) mPc = {bt[31:2], 2'b00};
      else    mPc = {mPc4[31:28], ji, 2'b00};
      mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
    end else if (!st) begin
      mInstr = mem[mPc[6:2]];
      mPc4   = mPc + 32'd4;
      mValid = 1'b1;
      mCnt   = mCnt + 1'b1;
      mPc    = mPc + 32'd4;
    end
  endtask

  task automatic addRow(input logic r, input logic st, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [25:0] ji, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [31:0] p4, input logic v,
                        input logic [CNT_W-1:0] c);
    vec_t row;
    row.rst = r; row.st = st; row.br = br; row.bt = bt; row.jp = jp; row.ji = ji;
    row.pc = pc; row.instr = ins; row.pc4 = p4; row.valid = v; row.cnt = c;
    vecs.push_back(row);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h2008_0020;

    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_index = '0;

    //     rst st br bt           jp ji        pc           instr          pc4          v  cnt
    addRow(0, 0, 0, 32'h0,       0, 26'h0,    32'h00,      32'h0,         32'h00,      0, 0);
    addRow(0, 0, 0, 32'h0,       0, 26'h0,    32'h00,      32'h0,         32'h00,      0, 0);
    addRow(1, 0, 0, 32'h0,       0, 26'h0,    32'h04,      32'h2008_0020, 32'h04,      1, 1);
    addRow(1, 0, 0, 32'h0,       0, 26'h0,    32'h08,      32'hA000_0001, 32'h08,      1, 2);
    addRow(1, 1, 0, 32'h0,       0, 26'h0,    32'h08,      32'hA000_0001, 32'h08,      1, 2);
    addRow(1, 1, 0, 32'h0,       0, 26'h0,    32'h08,      32'hA000_0001, 32'h08,      1, 2);
    addRow(1, 0, 0, 32'h0,       0, 26'h0,    32'h0C,      32'hA000_0002, 32'h0C,      1, 3);
    addRow(1, 0, 0, 32'h0,       0, 26'h0,    32'h10,      32'hA000_0003, 32'h10,      1, 4);
    addRow(1, 0, 0, 32'h0,       0, 26'h0,    32'h14,      32'hA000_0004, 32'h14,      1, 5);
    addRow(1, 0, 0, 32'h0,       0, 26'h0,    32'h18,      32'hA000_0005, 32'h18,      1, 6);
    addRow(1, 0, 0, 32'h0,       0, 26'h0,    32'h1C,      32'hA000_0006, 32'h1C,      1, 7);
    addRow(1, 0, 0, 32'h0,       0, 26'h0,    32'h20,      32'hA000_0007, 32'h20,      1, 8);
    addRow(1, 0, 0, 32'h0,       0, 26'h0,    32'h24,      32'hA000_0008, 32'h24,      1, 9);
    addRow(1, 0, 1, 32'h48,      0, 26'h0,    32'h48,      32'h0,         32'h00,      0, 9);
    addRow(1, 0, 0, 32'h0,       0, 26'h0,    32'h4C,      32'hA000_0012, 32'h4C,      1, 10);
    addRow(1, 0, 1, 32'h44,      0, 26'h0,    32'h44,      32'h0,         32'h00,      0, 10);
    addRow(1, 0, 0, 32'h0,       0, 26'h0,    32'h48,      32'hA000_0011, 32'h48,      1, 11);
    addRow(1, 0, 0, 32'h0,       1, 26'h0E,   32'h38,      32'h0,         32'h00,      0, 11);
    addRow(1, 0, 0, 32'h0,       0, 26'h0,    32'h3C,      32'hA000_000E, 32'h3C,      1, 12);
    addRow(1, 1, 1, 32'h7F,      1, 26'h3FF_FFFF, 32'h7C,  32'h0,         32'h00,      0, 12);
    addRow(1, 0, 0, 32'h0,       0, 26'h0,    32'h80,      32'hA000_001F, 32'h80,      1, 13);
    addRow(1, 0, 1, 32'h30,      0, 26'h0,    32'h30,      32'h0,         32'h00,      0, 13);
    addRow(0, 1, 1, 32'h100,     1, 26'h5,    32'h00,      32'h0,         32'h00,      0, 0);
    addRow(1, 0, 0, 32'h0,       0, 26'h0,    32'h04,      32'h2008_0020, 32'h04,      1, 1);

    // Settle under reset before the first row so the PC has a defined value.
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].br, vecs[i].bt, vecs[i].jp, vecs[i].ji);
      checkOutput($sformatf("row%0d pc_out", i),   pc_out,         vecs[i].pc);
      checkOutput($sformatf("row%0d instr", i),    if_id_instr,    vecs[i].instr);
      checkOutput($sformatf("row%0d pc_plus4", i), if_id_pc_plus4, vecs[i].pc4);
      checkOutput($sformatf("row%0d valid", i),    32'(if_id_valid), 32'(vecs[i].valid));
      checkOutput($sformatf("row%0d count", i),    32'(fetch_count), 32'(vecs[i].cnt));
    end

    // Random traffic; the first cycle is forced into reset so the model starts aligned.
    mPc = '0; mInstr = '0; mPc4 = '0; mValid = 1'b0; mCnt = '0;
    for (int i = 0; i < 600; i++) begin
      logic        r, st, br, jp;
      logic [31:0] bt;
      logic [25:0] ji;
      r  = (i != 0) && ($urandom_range(0, 31) != 0);
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 7) == 0);
      jp = ($urandom_range(0, 7) == 0);
      bt = $urandom;
      ji = 26'($urandom);
      modelStep(r, st, br, bt, jp, ji);
      applyStimulus(r, st, br, bt, jp, ji);
      checkOutput($sformatf("rnd%0d pc_out", i),   pc_out,         mPc);
      checkOutput($sformatf("rnd%0d instr", i),    if_id_instr,    mInstr);
      checkOutput($sformatf("rnd%0d pc_plus4", i), if_id_pc_plus4, mPc4);
      checkOutput($sformatf("rnd%0d valid", i),    32'(if_id_valid), 32'(mValid));
      checkOutput($sformatf("rnd%0d count", i),    32'(fetch_count), 32'(mCnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter, drives the word address into the `Instruction` memory, captures the returned word with its PC+4 into the IF/ID pipeline register, and applies stall, branch-redirect and jump-redirect requests from the hazard unit and later stages. It is the only producer of `PC` for the instruction memory and the only source of the decode stage's inputs.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `NOP_WORD`, default `32'h0000_0000`: instruction word inserted into IF/ID as a bubble.
- `CNT_W`, default `32`: width of the fetch counter.

- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset).
- `pc_out`  out  32  current PC, wired to `Instruction.PC`.
- `instr_in`  in  32  word returned combinationally by the instruction memory for `pc_out`.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `branch_taken`  in  1  taken branch resolved this cycle.
- `branch_target`  in  32  byte address of the taken branch.
- `jump`  in  1  decode stage has a `j` in IF/ID.
- `jump_index`  in  26  instr[25:0] of that `j`.
- `if_id_instr`  out  32  registered instruction.
- `if_id_pc_plus4`  out  32  registered PC+4 of that instruction.
- `if_id_valid`  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
- `fetch_count`  out  CNT_W  number of valid instructions loaded into IF/ID since reset.

## Operation
- Next-PC selection, priority high to low: reset → `RESET_PC`; `branch_taken` → `branch_target`; `jump` → `{if_id_pc_plus4[31:28], jump_index, 2'b00}`; `stall` → hold; else `pc_out + 4`.
- IF/ID update, same priority: reset → instr=`NOP_WORD`, pc_plus4=0, valid=0; `branch_taken` or `jump` → flush (instr=`NOP_WORD`, pc_plus4=0, valid=0); `stall` → hold all three; else instr=`instr_in`, pc_plus4=`pc_out+4`, valid=1.
- No branch delay slot: the wrong-path word fetched in the redirect cycle is always discarded.
- Redirect beats stall: the stall belongs to an instruction that is being squashed.
- `branch_taken` and `jump` together: branch wins (older instruction).
- `fetch_count` increments by 1 on every cycle IF/ID loads with valid=1; wraps modulo 2^CNT_W; reset to 0. Holds on stall and flush.
- PC arithmetic is 32-bit unsigned, wraps at 2^32. `pc_out[1:0]` is always 00; `branch_target[1:0]` is ignored (forced to 00). Address wrap into the 32-word memory window is the memory's concern, not this block's.

## Timing
- Reset values: `pc_out`=`RESET_PC`, `if_id_instr`=`NOP_WORD`, `if_id_pc_plus4`=0, `if_id_valid`=0, `fetch_count`=0.
- First cycle after reset deasserts: `pc_out`=0, memory word 0 on `instr_in`; next edge loads it into IF/ID (valid=1) and PC becomes 4.
- Fetch-to-IF/ID latency: 1 cycle. Redirect-to-new-PC latency: 1 cycle. Penalty of a taken branch or jump: 1 bubble.
- Reset asserted mid-operation overrides every other input on that edge; pending stall/redirect is lost.
- All outputs are registered except nothing combinational is exported; `pc_out` is a flop output.

## Structure
- Shared package `mips_pkg`: `RESET_PC`, `NOP_WORD`, `WORD_W=32`, `JIDX_W=26`, a `next_pc_sel_t` enum (SEQ, HOLD, BRANCH, JUMP, RESET).
- One sub-module `if_id_reg`: the IF/ID register with load/hold/flush controls; `fetch_stage` holds the PC flop, next-PC mux and counter.

## Test plan
- Reset held 2 cycles, then released → `pc_out` 0, 4, 8 on successive cycles; with memory word 0 = `32'h20080020`, `if_id_instr`=`32'h20080020`, `if_id_pc_plus4`=4, valid=1 one cycle after release; `fetch_count`=1.
- `stall` high 2 cycles at `pc_out`=8 → `pc_out` stays 8, IF/ID and `fetch_count` unchanged; after release resumes 12.
- `branch_taken`=1, `branch_target`=`32'h48` at `pc_out`=`32'h24` → next `pc_out`=`32'h48`, IF/ID instr=0, valid=0, count unchanged; following cycle loads word at 0x48.
- `jump`=1, `jump_index`=`26'h0E`, `if_id_pc_plus4`=`32'h48` → next `pc_out`=`32'h38`, IF/ID flushed.
- `stall`, `jump`, `branch_taken` (target `32'h7C`) all high → `pc_out`=`32'h7C`, IF/ID flushed.
- `reset` asserted for 1 cycle while `branch_taken`=1 at `pc_out`=`32'h30` → `pc_out`=0, all IF/ID outputs and `fetch_count` at reset values.
